// File: rtl/fir_out_shaper.sv
// Output conditioning for the FIR result stream: per-beat rounding right shift,
// saturation to OUT_W bits, 2-entry skid buffer, frame-length check and saturation count.
module fir_out_shaper #(
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             s_tvalid,
  input  logic [31:0]      s_tdata,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic             m_tvalid,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tlast,
  input  logic             m_tready,
  input  logic [4:0]       shift,
  input  logic [31:0]      data_length,
  input  logic             clr,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             err_len,
  output logic             frame_done,
  output logic [1:0]       dbg_state,
  output logic [31:0]      dbg_beat_cnt
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a raised valid holds with stable payload until it transfers.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] SAT_MIN = -SAT_MAX - 33'sd1;

  buf_state_t        state;
  buf_state_t        state_nxt;
  logic              ld_out_in;
  logic              ld_skid_in;
  logic              ld_out_skid;

  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic [OUT_W-1:0]  skid_data;
  logic              skid_last;
  logic              ready_q;

  logic              accept;
  logic              drain;

  logic signed [32:0] x_ext;
  logic [32:0]        rnd_bit;
  logic signed [32:0] sum;
  logic signed [32:0] shaped;
  logic               sat_hi;
  logic               sat_lo;
  logic [OUT_W-1:0]   sat_val;

  logic [31:0]        beat_cnt;
  logic [31:0]        beat_nxt;
  logic               len_bad;
  logic               sat_inc;

  assign accept       = s_tvalid & ready_q;
  assign drain        = m_tvalid & m_tready;
  assign s_tready     = ready_q;
  assign m_tvalid     = (state != ST_EMPTY);
  assign m_tdata      = out_data;
  assign m_tlast      = out_last;
  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;

  // Shaping in 33 bits so the rounding add cannot overflow for any shift.
  always_comb begin
    x_ext   = {s_tdata[31], s_tdata};
    rnd_bit = '0;
    if (shift != 5'd0) rnd_bit = 33'd1 << (shift - 5'd1);
    sum     = x_ext + $signed(rnd_bit);
    shaped  = sum >>> shift;
    sat_hi  = (shaped > SAT_MAX);
    sat_lo  = (shaped < SAT_MIN);
    if (sat_hi)      sat_val = SAT_MAX[OUT_W-1:0];
    else if (sat_lo) sat_val = SAT_MIN[OUT_W-1:0];
    else             sat_val = shaped[OUT_W-1:0];
  end

  always_comb begin
    state_nxt   = state;
    ld_out_in   = 1'b0;
    ld_skid_in  = 1'b0;
    ld_out_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          ld_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          state_nxt  = ST_FULL;
          ld_skid_in = 1'b1;
        end else if (!accept && drain) begin
          state_nxt = ST_EMPTY;
        end else if (accept && drain) begin
          ld_out_in = 1'b1;
        end
      end
      ST_FULL: begin
        // ready is low here, so only a drain can happen
        if (drain) begin
          state_nxt   = ST_ONE;
          ld_out_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      if (ld_out_in) begin
        out_data <= sat_val;
        out_last <= s_tlast;
      end else if (ld_out_skid) begin
        out_data <= skid_data;
        out_last <= skid_last;
      end
      if (ld_skid_in) begin
        skid_data <= sat_val;
        skid_last <= s_tlast;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) frame_done <= 1'b0;
    else             frame_done <= drain & m_tlast;
  end

  assign beat_nxt = beat_cnt + 32'd1;
  assign sat_inc  = accept & (sat_hi | sat_lo);
  // A frame is wrong if tlast arrives early/late, or the expected last beat lacks tlast.
  assign len_bad  = accept && (data_length != 32'd0) &&
                    (s_tlast ? (beat_nxt != data_length) : (beat_nxt == data_length));

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= s_tlast ? 32'd0 : beat_nxt;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sat_cnt <= '0;
      err_len <= 1'b0;
    end else if (clr) begin
      sat_cnt <= '0;
      err_len <= 1'b0;
    end else begin
      if (sat_inc && (sat_cnt != {CNT_W{1'b1}})) sat_cnt <= sat_cnt + CNT_W'(1);
      if (len_bad) err_len <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_shaper.sv
// Bench for fir_out_shaper: directed vectors, a spec-level model with a per-cycle
// compare process, and literal expectations for the documented examples.
module tb_fir_out_shaper;

  localparam int OUT_W = 16;
  localparam int CNT_W = 16;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic             axis_clk = 1'b0;
  logic             axis_rst_n;
  logic             s_tvalid;
  logic [31:0]      s_tdata;
  logic             s_tlast;
  logic             s_tready;
  logic             m_tvalid;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tlast;
  logic             m_tready;
  logic [4:0]       shift;
  logic [31:0]      data_length;
  logic             clr;
  logic [CNT_W-1:0] sat_cnt;
  logic             err_len;
  logic             frame_done;
  logic [1:0]       dbg_state;
  logic [31:0]      dbg_beat_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  logic [OUT_W:0] exp_q[$];
  longint obs_q[$];
  longint exp_lit[$];
  longint m_sat;
  logic   m_err;
  longint m_beats;
  logic   exp_fd;
  logic   prev_stall;
  logic [OUT_W-1:0] prev_data;
  logic   prev_last;
  int     edges;
  int     fd_count;
  logic   saw_not_ready;
  logic   rand_rdy;

  fir_out_shaper #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .shift(shift), .data_length(data_length), .clr(clr),
    .sat_cnt(sat_cnt), .err_len(err_len), .frame_done(frame_done),
    .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    if (!axis_rst_n) edges = 0;
    else edges = edges + 1;
  end

  always @(posedge axis_clk) begin
    if (rand_rdy) begin
      #2;
      m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    errors = errors + 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- checking helpers / model ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // floor((x + 2^(sh-1)) / 2^sh) with plain integer division
  function automatic longint shape(input longint x, input int sh);
    longint d, num, q;
    if (sh == 0) return x;
    d   = longint'(1) << sh;
    num = x + d / 2;
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint r);
    if (r > MAXV) return MAXV;
    if (r < MINV) return MINV;
    return r;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge axis_clk) begin
    longint r, rc, n;
    logic [OUT_W:0] e;
    logic fd_next;
    if (!axis_rst_n) begin
      chk("reset_outs", {m_tvalid, m_tlast, s_tready, err_len, frame_done, (|sat_cnt), (|m_tdata)}, 0);
      exp_q.delete();
      m_sat = 0; m_err = 1'b0; m_beats = 0; exp_fd = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("m_tvalid", m_tvalid, exp_q.size() != 0);
      chk("s_tready", s_tready, (edges > 0) && (exp_q.size() < 2));
      chk("frame_done", frame_done, exp_fd);
      chk("sat_cnt", sat_cnt, m_sat);
      chk("err_len", err_len, m_err);
      if (!s_tready) saw_not_ready = 1'b1;
      if (frame_done) fd_count = fd_count + 1;
      if (prev_stall) begin
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", m_tlast, prev_last);
      end
      fd_next = 1'b0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", $signed(m_tdata), $signed(e[OUT_W-1:0]));
          chk("m_tlast", m_tlast, e[OUT_W]);
        end
        obs_q.push_back(longint'($signed(m_tdata)));
        fd_next = m_tlast;
      end
      exp_fd     = fd_next;
      prev_stall = m_tvalid & !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (s_tvalid && s_tready) begin
        r  = shape(longint'($signed(s_tdata)), int'(shift));
        rc = clamp(r);
        exp_q.push_back({s_tlast, rc[OUT_W-1:0]});
        if (rc != r && m_sat < 65535) m_sat = m_sat + 1;
        n = m_beats + 1;
        if (data_length != 0 && ((s_tlast && n != longint'(data_length)) ||
                                 (!s_tlast && n == longint'(data_length)))) m_err = 1'b1;
        m_beats = s_tlast ? 0 : n;
      end
      if (clr) begin
        m_sat = 0;
        m_err = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input longint x, input logic last);
    int t;
    s_tvalid = 1'b1;
    s_tdata  = x[31:0];
    s_tlast  = last;
    t = 0;
    @(negedge axis_clk);
    while (!s_tready && t < 200) begin
      t = t + 1;
      @(negedge axis_clk);
    end
    if (t >= 200) chk("send_timeout", 1, 0);
    @(posedge axis_clk); #2;
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 2000) begin
      @(negedge axis_clk);
      t = t + 1;
    end
    if (t >= 2000) chk("drain_timeout", 1, 0);
    repeat (2) @(posedge axis_clk);
    #2;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge axis_clk); #2;
    clr = 1'b0;
  endtask

  task automatic check_obs(input string nm);
    chk({nm, "_count"}, obs_q.size(), exp_lit.size());
    for (int i = 0; i < exp_lit.size() && i < obs_q.size(); i++)
      chk(nm, obs_q[i], exp_lit[i]);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    axis_rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    m_tready = 1'b1; shift = '0; data_length = '0; clr = 1'b0;
    rand_rdy = 1'b0; fd_count = 0; saw_not_ready = 1'b0; edges = 0;
    m_sat = 0; m_err = 1'b0; m_beats = 0; exp_fd = 1'b0; prev_stall = 1'b0;

    // model pins
    chk("model_r24", shape(24, 4), 2);
    chk("model_rm24", shape(-24, 4), -1);
    chk("model_rm8", shape(-8, 4), 0);
    chk("model_r7", shape(7, 4), 0);
    chk("model_clamp", clamp(40000), 32767);

    // reset
    repeat (3) @(posedge axis_clk); #2;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_sat", sat_cnt, 0);
    axis_rst_n = 1'b1;
    #1 chk("tready_pre_edge", s_tready, 0);
    @(posedge axis_clk); #2;
    chk("tready_post_edge", s_tready, 1);

    // passthrough with latency
    obs_q.delete();
    send_beat(1234, 1'b0);
    chk("lat_valid", m_tvalid, 1);
    chk("lat_data", longint'($signed(m_tdata)), 1234);
    send_beat(-1234, 1'b0);
    idle(); wait_drain();
    exp_lit = '{1234, -1234};
    check_obs("pass");

    // rounding
    obs_q.delete(); shift = 5'd4;
    send_beat(24, 1'b0); send_beat(-24, 1'b0); send_beat(-8, 1'b0); send_beat(7, 1'b0);
    idle(); wait_drain();
    exp_lit = '{2, -1, 0, 0};
    check_obs("round");

    // saturation and clr
    obs_q.delete(); shift = 5'd0;
    clr_pulse();
    send_beat(40000, 1'b0); send_beat(-40000, 1'b0); send_beat(32767, 1'b0);
    idle(); wait_drain();
    exp_lit = '{32767, -32768, 32767};
    check_obs("sat");
    chk("sat_cnt_2", sat_cnt, 2);
    clr_pulse();
    chk("sat_cnt_clr", sat_cnt, 0);
    clr = 1'b1;
    send_beat(50000, 1'b0);
    clr = 1'b0;
    idle();
    chk("clr_wins", sat_cnt, 0);
    wait_drain();

    // backpressure
    obs_q.delete(); saw_not_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 10; i++) send_beat(i, 1'b0);
        idle();
      end
      begin
        repeat (2) @(posedge axis_clk); #2;
        m_tready = 1'b0;
        repeat (3) @(posedge axis_clk); #2;
        m_tready = 1'b1;
      end
    join
    wait_drain();
    exp_lit.delete();
    for (int i = 1; i <= 10; i++) exp_lit.push_back(i);
    check_obs("bp");
    chk("bp_ready_fell", saw_not_ready, 1);

    // length check
    data_length = 32'd4; clr_pulse();
    send_beat(1, 1'b0); send_beat(2, 1'b0); send_beat(3, 1'b1); idle();
    chk("len_short", err_len, 1);
    clr_pulse();
    send_beat(1, 1'b0); send_beat(2, 1'b0); send_beat(3, 1'b0); send_beat(4, 1'b0);
    chk("len_long", err_len, 1);
    send_beat(5, 1'b1); idle();
    clr_pulse();
    send_beat(1, 1'b0); send_beat(2, 1'b0); send_beat(3, 1'b0); send_beat(4, 1'b1); idle();
    chk("len_ok", err_len, 0);
    data_length = 32'd0; clr_pulse();
    send_beat(1, 1'b1);
    send_beat(2, 1'b0); send_beat(3, 1'b1);
    for (int i = 1; i <= 7; i++) send_beat(i, i == 7);
    idle(); wait_drain();
    chk("len_disabled", err_len, 0);

    // reset mid-frame with two beats buffered
    m_tready = 1'b0;
    send_beat(11, 1'b0); send_beat(12, 1'b0); idle();
    @(negedge axis_clk);
    chk("mid_full_ready", s_tready, 0);
    @(posedge axis_clk); #2;
    axis_rst_n = 1'b0;
    #1 chk("mid_rst_tvalid", m_tvalid, 0);
    repeat (2) @(posedge axis_clk); #2;
    axis_rst_n = 1'b1; m_tready = 1'b1;
    obs_q.delete();
    send_beat(77, 1'b1); idle(); wait_drain();
    exp_lit = '{77};
    check_obs("post_rst");

    // full 600-beat frame with random backpressure
    data_length = 32'd600; shift = 5'd0; clr_pulse();
    obs_q.delete(); fd_count = 0; rand_rdy = 1'b1;
    for (int i = 1; i <= 600; i++) send_beat(longint'(i) * 101 - 30000, i == 600);
    idle();
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge axis_clk); #3;
    m_tready = 1'b1;
    exp_lit.delete();
    for (int i = 1; i <= 600; i++) exp_lit.push_back(longint'(i) * 101 - 30000);
    check_obs("frame600");
    chk("frame600_done", fd_count, 1);
    chk("frame600_err", err_len, 0);
    chk("frame600_beat_cnt", dbg_beat_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_shaper.md
# fir_out_shaper

Output-conditioning stage directly downstream of the `fir` AXI-Stream master port (`sm_*`). It accepts 32-bit signed FIR results and applies a per-beat arithmetic right shift with round-half-up. It saturates each result to `OUT_W` signed bits and re-emits it on an AXI-Stream master through a 2-entry skid buffer. It also checks frame length against the programmed `data_length` and counts saturation events.

## Interface
- `OUT_W`, 16, output sample width (signed), 8..32
- `CNT_W`, 16, width of saturation counter
- `axis_clk`  in  1  sole clock, rising edge
- `axis_rst_n`  in  1  reset, asynchronous assert, active-low
- `s_tvalid`  in  1  input beat valid (from `fir` `sm_tvalid`)
- `s_tdata`  in  32  signed FIR result
- `s_tlast`  in  1  last beat of frame
- `s_tready`  out  1  input ready (to `fir` `sm_tready`)
- `m_tvalid`  out  1  output beat valid
- `m_tdata`  out  OUT_W  shaped signed sample
- `m_tlast`  out  1  last beat, passed through
- `m_tready`  in  1  downstream ready
- `shift`  in  5  right-shift amount, sampled on each accepted beat
- `data_length`  in  32  expected beats per frame; 0 disables the length check
- `clr`  in  1  synchronous pulse that clears `sat_cnt` and `err_len`
- `sat_cnt`  out  CNT_W  number of saturated beats; saturates at all-ones
- `err_len`  out  1  sticky frame-length mismatch
- `frame_done`  out  1  one-cycle pulse when a `tlast` beat leaves on `m_*`

## Operation
- **Accept:** a beat is accepted when `s_tvalid & s_tready`.
- **Shaping:** applied combinationally at acceptance, using 33-bit signed arithmetic.
  - `shift == 0`: `r = x`.
  - Otherwise: `r = (x + 2^(shift-1)) >>> shift`. Round half up: -24 with shift 4 gives -1; -8 with shift 4 gives 0.
- **Saturation:** clamp `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Each clamped accepted beat increments `sat_cnt`, which holds at its maximum.
- **Buffer:** the shaped beat goes into the output register; the skid register is used only when the output register is full and not draining. Beats are never lost or reordered.
- **States:** EMPTY (0 held), ONE (output register valid), FULL (output and skid valid). Transitions:
  - EMPTY, accept → ONE.
  - ONE, accept without drain → FULL.
  - ONE, drain without accept → EMPTY.
  - ONE, accept and drain together → ONE.
  - FULL, drain → ONE; skid moves to the output register.
  - A simultaneous accept in FULL is impossible because `s_tready` = 0.
- **Length check (`beat_cnt`, internal, 32-bit):**
  - Increments on each accept; clears to 0 on an accepted `tlast` beat.
  - When `data_length != 0`, `err_len` sets if a `tlast` beat is accepted with `beat_cnt + 1 != data_length`.
  - `err_len` also sets if a non-`tlast` beat is accepted with `beat_cnt + 1 == data_length`.
- **`clr`:** clears `sat_cnt` and `err_len`. If an increment or error coincides with `clr`, `clr` wins. `clr` does not affect `beat_cnt` or the buffer.
- **Reset (asynchronous, any time, including mid-frame):**
  - `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `s_tready`=0, `sat_cnt`=0, `err_len`=0, `frame_done`=0.
  - Buffer goes to EMPTY and `beat_cnt`=0; buffered beats are discarded.
  - `s_tready` rises to 1 on the first clock edge after reset release.

## Timing
- **Latency:** a beat accepted at edge N is visible on `m_*` after edge N, with `m_tvalid`=1 in cycle N+1.
- **Throughput:** 1 beat/cycle with `m_tready` held high.
- **`s_tready`:** registered; equals NOT(state == FULL) as of the last edge. With `m_tready` low, at most 2 beats are absorbed, then `s_tready` falls.
- **Output stability:** `m_tdata`/`m_tlast` stay stable while `m_tvalid & !m_tready`. `m_tvalid` never drops without a handshake.
- **`frame_done`:** registered; asserted in the cycle after the edge where `m_tvalid & m_tready & m_tlast`.
- **Counter/flag update:** `sat_cnt` and `err_len` update on the edge of the offending accept.

## Test plan
- **Reset:** hold `axis_rst_n`=0 → all outputs 0. Release → `s_tready`=1 after one edge. Assert reset mid-frame with 2 beats buffered → `m_tvalid`=0 immediately, no stale beats after release.
- **Passthrough and rounding:** `OUT_W`=16, `shift`=0, inputs 1234, -1234 → 1234, -1234 at one-cycle latency. With `shift`=4: input 24 → 2, -24 → -1, -8 → 0, 7 → 0.
- **Saturation:** `shift`=0, inputs 40000, -40000, 32767 → 32767, -32768, 32767 and `sat_cnt`=2. Pulse `clr` → `sat_cnt`=0.
- **Backpressure:** continuous input 1..10 with `m_tready` low for cycles 3–5 → `s_tready` falls after 2 buffered beats, output sequence exactly 1..10, `m_tdata` stable while stalled.
- **Length check:** `data_length`=4, `tlast` on beat 3 → `err_len`=1. `data_length`=4, beat 4 without `tlast` → `err_len`=1. `data_length`=0 with any `tlast` position → `err_len` stays 0.
- **Full FIR frame:** 600 beats with `tlast` on beat 600, `data_length`=600, `shift`=0, `m_tready` randomly toggled → 600 outputs in order, exactly one `frame_done` pulse, `err_len`=0, `beat_cnt` back to 0.
